// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: MEM/WB bundle field layout, datapath widths
// and the vector burst FSM state type.
package writeback_stage_pkg;

    localparam int BUNDLE_W  = 302;
    localparam int VEC_W     = 144;
    localparam int BEAT_W    = 36;
    localparam int SCALAR_W  = 24;
    localparam int RC_W      = 4;

    // MEM/WB bundle field offsets
    localparam int REGWRITEV_BIT = 301;
    localparam int MODESEL_BIT   = 300;
    localparam int OPTYPE_LSB    = 298;
    localparam int OPTYPE_W      = 2;
    localparam int OPCODE_LSB    = 294;
    localparam int OPCODE_W      = 4;
    localparam int MEMTOREG_BIT  = 293;
    localparam int REGWRITE_BIT  = 292;
    localparam int RC_LSB        = 288;
    localparam int MEMDATA_LSB   = 144;
    localparam int ALURESULT_LSB = 0;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_vector_serializer.sv
// Captures a vector result and streams it to the vector register file one beat per cycle,
// stalling upstream until the last beat. WB_FORWARD_EN exposes the held vector for forwarding.
module wb_vector_serializer #(
    parameter int VEC_W  = writeback_stage_pkg::VEC_W,
    parameter int BEAT_W = writeback_stage_pkg::BEAT_W
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [writeback_stage_pkg::RC_W-1:0] rc_in,
    input  logic [VEC_W-1:0]                    vec_in,
    output logic                                busy,
    output logic                                stall,
    output logic                                we,
    output logic [writeback_stage_pkg::RC_W-1:0] waddr,
    output logic [1:0]                          lane,
    output logic [BEAT_W-1:0]                   wdata
`ifdef WB_FORWARD_EN
    ,
    output logic                                last_beat,
    output logic [writeback_stage_pkg::RC_W-1:0] hold_rc,
    output logic [VEC_W-1:0]                    hold_vec
`endif
);
    import writeback_stage_pkg::*;

    localparam logic [1:0] LAST_BEAT = 2'(VEC_W / BEAT_W - 1);

    wb_state_t        state_q, state_d;
    logic [1:0]       beat_q, beat_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic [VEC_W-1:0] vec_q, vec_d;

    always_comb begin
        // NOTE: every _d takes its _q value first, so no branch below can leave one unassigned and infer a latch.
        state_d = state_q;
        beat_d  = beat_q;
        rc_d    = rc_q;
        vec_d   = vec_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BURST;
                    beat_d  = '0;
                    rc_d    = rc_in;
                    vec_d   = vec_in;
                end
            end
            BURST: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            // NOTE: the holding registers are cleared too, so an aborted burst leaves no stale vector behind.
            rc_q    <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            rc_q    <= rc_d;
            vec_q   <= vec_d;
        end
    end

    always_comb begin
        busy  = (state_q == BURST);
        stall = 1'b0;
        we    = 1'b0;
        waddr = '0;
        lane  = '0;
        wdata = '0;
        if (!rst) begin
            if (state_q == IDLE) begin
                stall = start;
            end else begin
                // Upstream is released during the final beat so the next bundle lands in IDLE.
                stall = (beat_q != LAST_BEAT);
                we    = 1'b1;
                waddr = rc_q;
                lane  = beat_q;
                wdata = vec_q[int'(beat_q) * BEAT_W +: BEAT_W];
            end
        end
    end

`ifdef WB_FORWARD_EN
    assign last_beat = !rst && (state_q == BURST) && (beat_q == LAST_BEAT);
    assign hold_rc   = rc_q;
    assign hold_vec  = vec_q;
`endif

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: selects the result, performs scalar writes directly and serialises vector
// writes into four beats. Define WB_FORWARD_EN to add the result forwarding ports.
module writeback_stage #(
    parameter int BUNDLE_W = writeback_stage_pkg::BUNDLE_W,
    parameter int VEC_W    = writeback_stage_pkg::VEC_W,
    parameter int BEAT_W   = writeback_stage_pkg::BEAT_W
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [BUNDLE_W-1:0]                     bufferIn,
    output logic                                    stall,
    output logic                                    weS,
    output logic [writeback_stage_pkg::RC_W-1:0]     waddrS,
    output logic [writeback_stage_pkg::SCALAR_W-1:0] wdataS,
    output logic                                    weV,
    output logic [writeback_stage_pkg::RC_W-1:0]     waddrV,
    output logic [1:0]                              laneV,
    output logic [BEAT_W-1:0]                       wdataV
`ifdef WB_FORWARD_EN
    ,
    output logic                                    fwdValid,
    output logic                                    fwdIsVec,
    output logic [writeback_stage_pkg::RC_W-1:0]     fwdRc,
    output logic [VEC_W-1:0]                        fwdData
`endif
);
    import writeback_stage_pkg::*;

    logic             reg_write_v;
    logic             reg_write;
    logic             mem_to_reg;
    logic [RC_W-1:0]  rc;
    logic [VEC_W-1:0] mem_data;
    logic [VEC_W-1:0] alu_result;
    logic [VEC_W-1:0] result;
    logic             vec_busy;

    assign reg_write_v = bufferIn[REGWRITEV_BIT];
    assign reg_write   = bufferIn[REGWRITE_BIT];
    assign mem_to_reg  = bufferIn[MEMTOREG_BIT];
    assign rc          = bufferIn[RC_LSB +: RC_W];
    assign mem_data    = bufferIn[MEMDATA_LSB +: VEC_W];
    assign alu_result  = bufferIn[ALURESULT_LSB +: VEC_W];
    assign result      = mem_to_reg ? mem_data : alu_result;

    // Mode and opcode fields travel with the bundle but do not steer writeback.
    logic unused_ctrl;
    assign unused_ctrl = ^{bufferIn[MODESEL_BIT], bufferIn[OPTYPE_LSB +: OPTYPE_W],
                           bufferIn[OPCODE_LSB +: OPCODE_W]};

`ifdef WB_FORWARD_EN
    logic             vec_last;
    logic [RC_W-1:0]  vec_hold_rc;
    logic [VEC_W-1:0] vec_hold;
`endif

    wb_vector_serializer #(
        .VEC_W  (VEC_W),
        .BEAT_W (BEAT_W)
    ) u_serializer (
        .clk      (clk),
        .rst      (rst),
        .start    (reg_write_v),
        .rc_in    (rc),
        .vec_in   (result),
        .busy     (vec_busy),
        .stall    (stall),
        .we       (weV),
        .waddr    (waddrV),
        .lane     (laneV),
        .wdata    (wdataV)
`ifdef WB_FORWARD_EN
        ,
        .last_beat(vec_last),
        .hold_rc  (vec_hold_rc),
        .hold_vec (vec_hold)
`endif
    );

    // The bundle is held upstream during a burst, so gating on vec_busy keeps the scalar write single.
    always_comb begin
        weS    = 1'b0;
        waddrS = '0;
        wdataS = '0;
        if (!rst && !vec_busy && reg_write) begin
            weS    = 1'b1;
            waddrS = rc;
            wdataS = result[SCALAR_W-1:0];
        end
    end

`ifdef WB_FORWARD_EN
    always_comb begin
        fwdValid = 1'b0;
        fwdIsVec = 1'b0;
        fwdRc    = '0;
        fwdData  = '0;
        if (vec_last) begin
            fwdValid = 1'b1;
            fwdIsVec = 1'b1;
            fwdRc    = vec_hold_rc;
            fwdData  = vec_hold;
        end else if (weS) begin
            fwdValid = 1'b1;
            fwdRc    = rc;
            fwdData  = result;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: expected writes are queued as bundles are issued and
// checked as the DUT emits them. Forwarding checks are compiled in with WB_FORWARD_EN.
`timescale 1ns/1ps
module tb_writeback_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [301:0] bufferIn;
    logic         stall, weS, weV;
    logic [3:0]   waddrS, waddrV;
    logic [23:0]  wdataS;
    logic [1:0]   laneV;
    logic [35:0]  wdataV;
`ifdef WB_FORWARD_EN
    logic         fwdValid, fwdIsVec;
    logic [3:0]   fwdRc;
    logic [143:0] fwdData;
`endif

    writeback_stage dut (
        .clk      (clk),
        .rst      (rst),
        .bufferIn (bufferIn),
        .stall    (stall),
        .weS      (weS),
        .waddrS   (waddrS),
        .wdataS   (wdataS),
        .weV      (weV),
        .waddrV   (waddrV),
        .laneV    (laneV),
        .wdataV   (wdataV)
`ifdef WB_FORWARD_EN
        ,
        .fwdValid (fwdValid),
        .fwdIsVec (fwdIsVec),
        .fwdRc    (fwdRc),
        .fwdData  (fwdData)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]   rc;
        logic [23:0]  data;
        logic [143:0] full;
    } s_exp_t;

    typedef struct packed {
        logic [3:0]   rc;
        logic [1:0]   lane;
        logic [35:0]  data;
        logic [143:0] full;
    } v_exp_t;

    s_exp_t s_q[$];
    v_exp_t v_q[$];
    int     wv_cyc[$];
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    int     ws_count = 0;
    int     wv_count = 0;
    int     fwd_vec_count = 0;
    s_exp_t se;
    v_exp_t ve;

    always @(posedge clk) cyc++;

    // Output monitor: pops the scoreboard whenever a write pulse appears.
    always @(negedge clk) begin
        if (weS === 1'b1) begin
            ws_count++;
            checks++;
            if (s_q.size() == 0) begin
                failures++;
                $display("FAIL scalar_unexpected addr=%0d data=%h", waddrS, wdataS);
            end else begin
                se = s_q.pop_front();
                if (waddrS !== se.rc || wdataS !== se.data) begin
                    failures++;
                    $display("FAIL scalar_write got addr=%0d data=%h want addr=%0d data=%h",
                             waddrS, wdataS, se.rc, se.data);
                end
`ifdef WB_FORWARD_EN
                checks++;
                if (fwdValid !== 1'b1 || fwdIsVec !== 1'b0 || fwdRc !== se.rc || fwdData !== se.full) begin
                    failures++;
                    $display("FAIL fwd_scalar got v=%b vec=%b rc=%0d data=%h want rc=%0d data=%h",
                             fwdValid, fwdIsVec, fwdRc, fwdData, se.rc, se.full);
                end
`endif
            end
        end else begin
            checks++;
            if (waddrS !== 4'd0 || wdataS !== 24'd0) begin
                failures++;
                $display("FAIL scalar_idle_zero got addr=%0d data=%h want 0", waddrS, wdataS);
            end
        end

        if (weV === 1'b1) begin
            wv_count++;
            wv_cyc.push_back(cyc);
            checks++;
            if (v_q.size() == 0) begin
                failures++;
                $display("FAIL vector_unexpected addr=%0d lane=%0d data=%h", waddrV, laneV, wdataV);
            end else begin
                ve = v_q.pop_front();
                if (waddrV !== ve.rc || laneV !== ve.lane || wdataV !== ve.data) begin
                    failures++;
                    $display("FAIL vector_beat got addr=%0d lane=%0d data=%h want addr=%0d lane=%0d data=%h",
                             waddrV, laneV, wdataV, ve.rc, ve.lane, ve.data);
                end
`ifdef WB_FORWARD_EN
                checks++;
                if (ve.lane == 2'd3) begin
                    if (fwdValid !== 1'b1 || fwdIsVec !== 1'b1 || fwdRc !== ve.rc || fwdData !== ve.full) begin
                        failures++;
                        $display("FAIL fwd_vector got v=%b vec=%b rc=%0d data=%h want rc=%0d data=%h",
                                 fwdValid, fwdIsVec, fwdRc, fwdData, ve.rc, ve.full);
                    end
                end else if (fwdValid !== 1'b0) begin
                    failures++;
                    $display("FAIL fwd_early_beat got fwdValid=%b want 0 on lane %0d", fwdValid, ve.lane);
                end
`endif
            end
        end else begin
            checks++;
            if (waddrV !== 4'd0 || laneV !== 2'd0 || wdataV !== 36'd0) begin
                failures++;
                $display("FAIL vector_idle_zero got addr=%0d lane=%0d data=%h want 0", waddrV, laneV, wdataV);
            end
        end

`ifdef WB_FORWARD_EN
        if (fwdValid === 1'b1 && fwdIsVec === 1'b1) fwd_vec_count++;
        if (weS !== 1'b1 && weV !== 1'b1) begin
            checks++;
            if (fwdValid !== 1'b0) begin
                failures++;
                $display("FAIL fwd_idle got fwdValid=%b want 0", fwdValid);
            end
        end
`endif
    end

    function automatic logic [301:0] mk(input logic rwv, input logic rw, input logic m2r,
                                         input logic [3:0] rc, input logic [143:0] mem,
                                         input logic [143:0] alu, input logic [6:0] ctrl);
        return {rwv, ctrl[6], ctrl[5:4], ctrl[3:0], m2r, rw, rc, mem, alu};
    endfunction

    function automatic logic [143:0] rand144();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[143:0];
    endfunction

    task automatic push_expect(input logic [301:0] b);
        logic [143:0] res;
        res = b[293] ? b[287:144] : b[143:0];
        if (b[292]) s_q.push_back('{rc: b[291:288], data: res[23:0], full: res});
        if (b[301]) begin
            for (int i = 0; i < 4; i++) begin
                v_q.push_back('{rc: b[291:288], lane: 2'(i), data: res[i*36 +: 36], full: res});
            end
        end
    endtask

    // Acts as the upstream stage: holds the bundle until stall drops, then advances.
    task automatic send(input logic [301:0] b, output int stall_cycles);
        int n;
        bufferIn = b;
        stall_cycles = 0;
        n = 0;
        do begin
            @(negedge clk);
            if (stall === 1'b1) stall_cycles++;
            n++;
        end while (stall !== 1'b0 && n < 20);
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL send_timeout stall=%b after %0d cycles want 0", stall, n);
        end
        @(posedge clk);
        #1;
        bufferIn = '0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((s_q.size() != 0 || v_q.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (s_q.size() != 0 || v_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending scalar=%0d vector=%0d want 0", s_q.size(), v_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bufferIn = mk(1'b1, 1'b1, 1'b0, 4'd5, rand144(), rand144(), 7'h3C);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({stall, weS, weV} !== 3'b000 || waddrS !== 4'd0 || wdataS !== 24'd0 ||
                waddrV !== 4'd0 || laneV !== 2'd0 || wdataV !== 36'd0) begin
                failures++;
                $display("FAIL reset_outputs got stall=%b weS=%b weV=%b addrS=%0d dataS=%h addrV=%0d lane=%0d dataV=%h want all 0",
                         stall, weS, weV, waddrS, wdataS, waddrV, laneV, wdataV);
            end
        end
        @(posedge clk);
        #1;
        bufferIn = '0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall, weS, weV} !== 3'b000) begin
            failures++;
            $display("FAIL post_reset_idle got stall=%b weS=%b weV=%b want 000", stall, weS, weV);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_no_write();
        bufferIn = mk(1'b0, 1'b0, 1'b1, 4'hF, rand144(), rand144(), 7'h7F);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({stall, weS, weV} !== 3'b000) begin
                failures++;
                $display("FAIL no_write got stall=%b weS=%b weV=%b want 000", stall, weS, weV);
            end
        end
        @(posedge clk);
        #1;
        bufferIn = '0;
    endtask

    task automatic test_scalar();
        logic [301:0] b;
        logic [143:0] mem;
        int sc, ws0;
        ws0 = ws_count;
        b = mk(1'b0, 1'b1, 1'b0, 4'd5, 144'h0, 144'h00ABCDEF, 7'h55);
        s_q.push_back('{rc: 4'd5, data: 24'hABCDEF, full: 144'h00ABCDEF});
        send(b, sc);
        checks++;
        if (sc != 0) begin
            failures++;
            $display("FAIL scalar_stall got %0d stall cycles want 0", sc);
        end
        mem = rand144();
        b = mk(1'b0, 1'b1, 1'b1, 4'd12, mem, rand144(), 7'h2B);
        s_q.push_back('{rc: 4'd12, data: mem[23:0], full: mem});
        send(b, sc);
        wait_drain();
        checks++;
        if (ws_count - ws0 != 2) begin
            failures++;
            $display("FAIL scalar_count got %0d weS pulses want 2", ws_count - ws0);
        end
    endtask

    task automatic test_vector_load();
        logic [143:0] vec;
        int sc, wv0;
        vec = 144'h111111111222222222333333333444444444;
        wv0 = wv_count;
        v_q.push_back('{rc: 4'd3, lane: 2'd0, data: 36'h444444444, full: vec});
        v_q.push_back('{rc: 4'd3, lane: 2'd1, data: 36'h333333333, full: vec});
        v_q.push_back('{rc: 4'd3, lane: 2'd2, data: 36'h222222222, full: vec});
        v_q.push_back('{rc: 4'd3, lane: 2'd3, data: 36'h111111111, full: vec});
        send(mk(1'b1, 1'b0, 1'b1, 4'd3, vec, 144'hDEAD, 7'h2A), sc);
        checks++;
        if (sc != 4) begin
            failures++;
            $display("FAIL vector_stall got %0d stall cycles want 4", sc);
        end
        wait_drain();
        checks++;
        if (wv_count - wv0 != 4) begin
            failures++;
            $display("FAIL vector_count got %0d weV pulses want 4", wv_count - wv0);
        end
    endtask

    task automatic test_both_flags();
        logic [301:0] b;
        int sc, ws0, wv0;
        ws0 = ws_count;
        wv0 = wv_count;
        b = mk(1'b1, 1'b1, 1'b0, 4'd7, rand144(), rand144(), 7'h11);
        push_expect(b);
        send(b, sc);
        wait_drain();
        checks++;
        if (ws_count - ws0 != 1 || wv_count - wv0 != 4 || sc != 4) begin
            failures++;
            $display("FAIL both_flags got weS=%0d weV=%0d stall=%0d want 1 4 4",
                     ws_count - ws0, wv_count - wv0, sc);
        end
    endtask

    task automatic test_back_to_back();
        logic [301:0] b1, b2;
        int sc1, sc2;
        b1 = mk(1'b1, 1'b0, 1'b0, 4'd1, rand144(), rand144(), 7'h00);
        b2 = mk(1'b1, 1'b0, 1'b1, 4'd2, rand144(), rand144(), 7'h7E);
        wv_cyc.delete();
        push_expect(b1);
        push_expect(b2);
        send(b1, sc1);
        send(b2, sc2);
        wait_drain();
        checks++;
        if (wv_cyc.size() != 8) begin
            failures++;
            $display("FAIL b2b_count got %0d weV pulses want 8", wv_cyc.size());
        end else begin
            checks++;
            if (wv_cyc[4] - wv_cyc[3] != 2) begin
                failures++;
                $display("FAIL b2b_gap got %0d cycles want 2", wv_cyc[4] - wv_cyc[3]);
            end
        end
    endtask

    task automatic test_random();
        logic [301:0] b;
        logic rwv, rw;
        int sc;
        for (int i = 0; i < 8; i++) begin
            rwv = 1'($urandom_range(0, 1));
            rw  = 1'($urandom_range(0, 1));
            b = mk(rwv, rw, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   rand144(), rand144(), 7'($urandom_range(0, 127)));
            push_expect(b);
            send(b, sc);
            checks++;
            if (sc != (rwv ? 4 : 0)) begin
                failures++;
                $display("FAIL random_stall iter=%0d got %0d want %0d", i, sc, rwv ? 4 : 0);
            end
        end
        wait_drain();
    endtask

    task automatic test_reset_abort();
        logic [143:0] vec;
        int wv0;
        vec = rand144();
        wv0 = wv_count;
        v_q.push_back('{rc: 4'd4, lane: 2'd0, data: vec[35:0], full: vec});
        v_q.push_back('{rc: 4'd4, lane: 2'd1, data: vec[71:36], full: vec});
        bufferIn = mk(1'b1, 1'b0, 1'b0, 4'd4, 144'h0, vec, 7'h00);
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL abort_accept got stall=%b want 1", stall);
        end
        @(posedge clk);
        #1;
        bufferIn = '0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (weV !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL abort_in_reset got weV=%b stall=%b want 0 0", weV, stall);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (weV !== 1'b0 || stall !== 1'b0) begin
                failures++;
                $display("FAIL abort_after got weV=%b stall=%b want 0 0", weV, stall);
            end
        end
        checks++;
        if (wv_count - wv0 != 2 || v_q.size() != 0) begin
            failures++;
            $display("FAIL abort_count got %0d beats pending=%0d want 2 0", wv_count - wv0, v_q.size());
        end
        @(posedge clk);
        #1;
    endtask

`ifdef WB_FORWARD_EN
    task automatic test_forward();
        logic [301:0] b;
        int sc, f0;
        f0 = fwd_vec_count;
        b = mk(1'b1, 1'b0, 1'b0, 4'd9, rand144(), rand144(), 7'h19);
        push_expect(b);
        send(b, sc);
        wait_drain();
        checks++;
        if (fwd_vec_count - f0 != 1) begin
            failures++;
            $display("FAIL fwd_vec_cycles got %0d want 1", fwd_vec_count - f0);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_no_write();
        test_scalar();
        test_vector_load();
        test_both_flags();
        test_back_to_back();
        test_random();
        test_reset_abort();
`ifdef WB_FORWARD_EN
        test_forward();
`endif
        test_scalar();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
